uart_rx_buffer: RTL and testbench
=================================

# uart_rx_buffer

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each single-cycle byte-complete strobe and its data into a synchronous FIFO. It presents the bytes in first-word-fall-through order to the CPU/MMIO read side, with an occupancy count, a sticky overflow flag and a level-based interrupt request. Bytes are never reordered. A byte arriving while the buffer is full is dropped and flagged.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, at least 2.
- `IRQ_LEVEL`, 1: `irq` asserts when occupancy is at least this value; range 1..`DEPTH`.
- `clk` input 1: single system clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low (0 = in reset); clears all state immediately.
- `rx_done` input 1: byte-complete strobe from the UART receiver, high for one cycle per byte.
- `rx_data` input 8: received byte, valid in the cycle `rx_done` is high.
- `rd_en` input 1: pop request; consumes the head entry when `rd_valid` is 1.
- `rd_data` output 8: head entry; meaningful only while `rd_valid` is 1.
- `rd_valid` output 1: buffer non-empty.
- `count` output log2(`DEPTH`)+1: current occupancy, 0..`DEPTH`.
- `full` output 1: `count` equals `DEPTH`.
- `overflow` output 1: sticky; set when a byte is dropped.
- `clr_overflow` input 1: clears `overflow`.
- `flush` input 1: synchronous empty; discards all entries.
- `irq` output 1: registered, equals (`count` >= `IRQ_LEVEL`).

## Operation
- Storage is `DEPTH` x 8 memory with write and read pointers of log2(`DEPTH`) bits that wrap modulo `DEPTH`. A separate occupancy counter is log2(`DEPTH`)+1 bits.
- A push is `rx_done` and not `flush`. A pop is `rd_en` and `rd_valid` and not `flush`.
- Push when not full: write `rx_data` at the write pointer, then increment the write pointer.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and `count` stays at `DEPTH`.
  - Otherwise the byte is dropped, `overflow` is set, and pointers and `count` are unchanged.
- Pop: increment the read pointer. A pop while empty is ignored; no state changes.
- Simultaneous push and pop with `count` >= 1: both pointers advance and `count` is unchanged.
- Simultaneous push and pop with `count` = 0: the pop is ignored and the push proceeds.
- `flush`:
  - Zeroes both pointers and `count`.
  - Any same-cycle push is discarded without setting `overflow`.
  - `overflow` is unaffected unless `clr_overflow` is also high.
- `overflow` priority: a same-cycle set beats `clr_overflow`, so a drop in the clear cycle leaves the flag at 1.
- `rd_data` is the memory entry at the read pointer (FWFT). After a pop it shows the next entry in the following cycle.
- Reset values: `rd_data`=0 (memory read of a zeroed array is not required; `rd_data` is don't-care while `rd_valid`=0, and is driven 0 under reset), `rd_valid`=0, `count`=0, `full`=0, `overflow`=0, `irq`=0, both pointers 0.

## Timing
- Push latency: a byte strobed in cycle N gives `rd_valid`=1, `rd_data`=byte and the updated `count` in cycle N+1.
- Pop latency: a pop in cycle N shows the next head (or `rd_valid`=0) in cycle N+1.
- `count`, `full` and `rd_valid` are registered, or derived combinationally from registered state only. There is no combinational path from `rx_done` or `rd_en` to any output.
- `irq` is registered from the next-state `count`, so it updates in the same cycle as `count`.
- Back-to-back `rx_done` on consecutive cycles must be supported, even though the upstream UART cannot produce it.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. The first push after release behaves as on an empty buffer.

## Structure
- Shared package: `UART_DATA_W`=8, plus a `clog2`-style width helper used for the pointer and `count` widths.
- One natural sub-module, `fifo_sync_fwft`, a generic parameterised width/depth FIFO.
  - It has push/pop, count, full and empty outputs.
  - `uart_rx_buffer` wraps it and adds the overflow, flush gating and irq logic.
- No other hierarchy.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on separate cycles:
  - `count` steps 1, 2, 3.
  - `rd_data`=0x41 with `rd_valid`=1 one cycle after the first strobe.
  - Three pops return 0x41, 0x42, 0x43, then `rd_valid`=0.
- Fill with 0x00..0x0F (`DEPTH`=16), then push 0xAA:
  - `full`=1 and `overflow`=1.
  - Draining returns 0x00..0x0F and no 0xAA.
  - `clr_overflow` then gives `overflow`=0.
- Full buffer, push 0x55 and pop in the same cycle:
  - `count` stays 16 and `overflow` stays 0.
  - The last byte drained is 0x55.
- Empty buffer, push 0x10 and `rd_en` in the same cycle: `count`=1 and `rd_data`=0x10 next cycle.
- `IRQ_LEVEL`=4:
  - `irq` rises with the 4th push in the cycle `count`=4.
  - It falls with the pop that makes `count`=3.
  - `flush` with 5 entries gives `count`=0, `irq`=0 next cycle.
- Assert `reset`=0 asynchronously mid-stream with 6 entries: all outputs are 0 before the next clock edge, and a subsequent push of 0x77 reads back 0x77.

Source files
------------

// File: rtl/uart_rx_buffer_pkg.sv
// Shared constants and width helpers for the UART receive buffer.
// Imported by the FIFO core and the buffer wrapper.
package uart_rx_buffer_pkg;

   localparam int UART_DATA_W = 8;

   // Bits needed to index n entries; the result is 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_sync_fwft.sv
// Generic synchronous first-word-fall-through FIFO.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fifo_sync_fwft
   import uart_rx_buffer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    count_nxt,
   output logic             full,
   output logic             empty,
   output logic             pop_ok
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   assign pop_ok  = pop & ~empty & ~clr;
   assign push_ok = push & ~clr & (~full | pop_ok);

   // Head is zero while empty so the output is clean out of reset.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (clr) begin
         count_nxt = '0;
      end else begin
         unique case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
         endcase
      end
   end

   // When full, wr_ptr aliases rd_ptr; the head is consumed on the same edge.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive byte buffer: FWFT FIFO plus overflow flag, flush and level irq.
// No combinational path runs from rx_done or rd_en to any output.
module uart_rx_buffer
   import uart_rx_buffer_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int IRQ_LEVEL = 1,
   localparam int CW = clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx_done,
   input  logic [UART_DATA_W-1:0] rx_data,
   input  logic                   rd_en,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   rd_valid,
   output logic [CW-1:0]          count,
   output logic                   full,
   output logic                   overflow,
   input  logic                   clr_overflow,
   input  logic                   flush,
   output logic                   irq
);

   localparam logic [CW-1:0] IRQ_LV = CW'(IRQ_LEVEL);

   logic          push;
   logic          pop;
   logic          empty;
   logic          pop_ok;
   logic          drop;
   logic [CW-1:0] count_nxt;

   assign push = rx_done & ~flush;
   assign pop  = rd_en & ~flush;

   fifo_sync_fwft #(
      .WIDTH (UART_DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clr       (flush),
      .push      (push),
      .pop       (pop),
      .wr_data   (rx_data),
      .rd_data   (rd_data),
      .count     (count),
      .count_nxt (count_nxt),
      .full      (full),
      .empty     (empty),
      .pop_ok    (pop_ok)
   );

   assign rd_valid = ~empty;
   assign drop     = push & full & ~pop_ok;

   // A drop in the clear cycle wins so no lost byte goes unreported.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
         irq <= (count_nxt >= IRQ_LV);
      end
   end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed self-checking bench for uart_rx_buffer (DEPTH=16, IRQ_LEVEL=4).
// Each scenario task drives stimulus and checks outputs one step after the edge.
module tb_uart_rx_buffer;

   logic       clk;
   logic       reset;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [4:0] count;
   logic       full;
   logic       overflow;
   logic       clr_overflow;
   logic       flush;
   logic       irq;

   int n_tests = 0;
   int n_fail  = 0;

   uart_rx_buffer #(.DEPTH(16), .IRQ_LEVEL(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done      (rx_done),
      .rx_data      (rx_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .full         (full),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .flush        (flush),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      rx_done = 1'b1;
      rx_data = b;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      rd_en = 1'b0;
      clr_overflow = 1'b0;
      flush = 1'b0;
      tick();
      tick();
      n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
      n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rd_valid); end
      n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", rd_data); end
      n_tests++; if ({full, overflow, irq} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {full, overflow, irq}); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] exp_b;
      push(8'h41);
      n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL basic_cnt1 got %0d want 1", count); end
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== 8'h41) begin n_fail++; $display("FAIL basic_head got v=%b d=%h want v=1 d=41", rd_valid, rd_data); end
      push(8'h42);
      n_tests++; if (count !== 5'd2) begin n_fail++; $display("FAIL basic_cnt2 got %0d want 2", count); end
      push(8'h43);
      n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL basic_cnt3 got %0d want 3", count); end
      for (int i = 0; i < 3; i++) begin
         exp_b = 8'h41 + 8'(i);
         n_tests++; if (rd_data !== exp_b) begin n_fail++; $display("FAIL basic_pop%0d got %h want %h", i, rd_data, exp_b); end
         pop();
      end
      n_tests++; if (rd_valid !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL basic_empty got v=%b c=%0d want v=0 c=0", rd_valid, count); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) push(8'(i));
      n_tests++; if (full !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL ovf_full got f=%b c=%0d want f=1 c=16", full, count); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b want 0", overflow); end
      push(8'hAA);
      n_tests++; if (overflow !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL ovf_set got o=%b c=%0d want o=1 c=16", overflow, count); end
      clr_overflow = 1'b1;
      push(8'hBB);
      clr_overflow = 1'b0;
      n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_prio got %b want 1", overflow); end
      for (int i = 0; i < 16; i++) begin
         n_tests++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL ovf_drain%0d got %h want %h", i, rd_data, 8'(i)); end
         pop();
      end
      n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_extra got v=%b d=%h want v=0", rd_valid, rd_data); end
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b want 0", overflow); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 16; i++) push(8'(i));
      rx_done = 1'b1;
      rx_data = 8'h55;
      rd_en = 1'b1;
      tick();
      rx_done = 1'b0;
      rd_en = 1'b0;
      n_tests++; if (count !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_cnt got c=%0d o=%b want c=16 o=0", count, overflow); end
      n_tests++; if (rd_data !== 8'h01) begin n_fail++; $display("FAIL fpp_head got %h want 01", rd_data); end
      for (int i = 1; i < 16; i++) begin
         n_tests++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL fpp_drain%0d got %h want %h", i, rd_data, 8'(i)); end
         pop();
      end
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== 8'h55) begin n_fail++; $display("FAIL fpp_last got v=%b d=%h want v=1 d=55", rd_valid, rd_data); end
      pop();
      n_tests++; if (rd_valid !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL fpp_empty got v=%b c=%0d want v=0 c=0", rd_valid, count); end
   endtask

   task automatic test_empty_push_pop();
      rx_done = 1'b1;
      rx_data = 8'h10;
      rd_en = 1'b1;
      tick();
      rx_done = 1'b0;
      rd_en = 1'b0;
      n_tests++; if (count !== 5'd1 || rd_data !== 8'h10) begin n_fail++; $display("FAIL epp got c=%0d d=%h want c=1 d=10", count, rd_data); end
      pop();
      n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL epp_pop got %0d want 0", count); end
      pop();
      n_tests++; if (count !== 5'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL epp_idle got c=%0d v=%b want c=0 v=0", count, rd_valid); end
   endtask

   task automatic test_irq_flush();
      for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_3 got %b want 0", irq); end
      push(8'h63);
      n_tests++; if (irq !== 1'b1 || count !== 5'd4) begin n_fail++; $display("FAIL irq_4 got i=%b c=%0d want i=1 c=4", irq, count); end
      pop();
      n_tests++; if (irq !== 1'b0 || count !== 5'd3) begin n_fail++; $display("FAIL irq_fall got i=%b c=%0d want i=0 c=3", irq, count); end
      push(8'h64);
      push(8'h65);
      n_tests++; if (irq !== 1'b1 || count !== 5'd5) begin n_fail++; $display("FAIL irq_5 got i=%b c=%0d want i=1 c=5", irq, count); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_tests++; if (count !== 5'd0 || irq !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush got c=%0d i=%b v=%b want 0 0 0", count, irq, rd_valid); end
      for (int i = 0; i < 16; i++) push(8'(i));
      flush = 1'b1;
      push(8'hEE);
      flush = 1'b0;
      n_tests++; if (count !== 5'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL flush_push got c=%0d o=%b want c=0 o=0", count, overflow); end
      push(8'h21);
      n_tests++; if (rd_data !== 8'h21 || count !== 5'd1) begin n_fail++; $display("FAIL flush_after got d=%h c=%0d want d=21 c=1", rd_data, count); end
      pop();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
      n_tests++; if (count !== 5'd6 || irq !== 1'b1) begin n_fail++; $display("FAIL ar_pre got c=%0d i=%b want c=6 i=1", count, irq); end
      #2 reset = 1'b0;
      #1;
      n_tests++; if (count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_fail++; $display("FAIL ar_out got c=%0d v=%b d=%h want 0 0 00", count, rd_valid, rd_data); end
      n_tests++; if ({full, overflow, irq} !== 3'b000) begin n_fail++; $display("FAIL ar_flags got %b want 000", {full, overflow, irq}); end
      tick();
      reset = 1'b1;
      push(8'h77);
      n_tests++; if (rd_data !== 8'h77 || count !== 5'd1 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL ar_push got d=%h c=%0d v=%b want 77 1 1", rd_data, count, rd_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_empty_push_pop();
      test_irq_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
